// File: rtl/mac_operand_sequencer.sv
// Feeds one dot-product vector from operand FIFOs A/B into the FP MAC, tagging first/last pairs.
// Optional stall counter output enabled by defining MAC_SEQ_STALL_CNT_EN.
module mac_operand_sequencer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             a_empty,
  input  logic             b_empty,
  output logic             a_rden,
  output logic             b_rden,
  input  logic [WIDTH-1:0] a_rddata,
  input  logic [WIDTH-1:0] b_rddata,
  output logic [WIDTH-1:0] mac_a,
  output logic [WIDTH-1:0] mac_b,
  output logic             mac_valid,
  input  logic             mac_ready,
  output logic             mac_clr,
  output logic             mac_last,
  output logic             busy,
`ifdef MAC_SEQ_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr;
    logic             last;
  } pair_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining_q, issued_q;
  logic [1:0]       credits_q;
  logic             pop, hs, start_ok;

  // Pair currently arriving from the FIFOs (popped last cycle) and its flags.
  logic             pop_d_q, in_clr_q, in_last_q;
  pair_t            incoming, head;

  pair_t            buf_mem [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic             head_valid;

  assign start_ok   = (state_q == IDLE) && start;
  assign pop        = (state_q == RUN) && !a_empty && !b_empty &&
                      (credits_q != 2'd0) && (remaining_q != '0);
  assign incoming   = '{a: a_rddata, b: b_rddata, clr: in_clr_q, last: in_last_q};
  // An empty buffer presents the arriving pair directly so mac_valid follows a pop by one cycle.
  assign head_valid = (count_q != 2'd0) || pop_d_q;
  assign head       = (count_q != 2'd0) ? buf_mem[rd_ptr_q] : incoming;
  assign hs         = head_valid && mac_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (vec_len != '0) ? RUN : DONE;
      RUN:     if (pop && remaining_q == LEN_W'(1)) state_d = DRAIN;
      DRAIN:   if (hs && head.last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    a_rden    = pop;
    b_rden    = pop;
    mac_valid = head_valid;
    mac_a     = head_valid ? head.a : '0;
    mac_b     = head_valid ? head.b : '0;
    mac_clr   = head_valid && head.clr;
    mac_last  = head_valid && head.last;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      remaining_q <= '0;
      issued_q    <= '0;
      credits_q   <= 2'd2;
      pop_d_q     <= 1'b0;
      in_clr_q    <= 1'b0;
      in_last_q   <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      if (start_ok) begin
        remaining_q <= vec_len;
        issued_q    <= '0;
      end else if (pop) begin
        remaining_q <= remaining_q - LEN_W'(1);
        issued_q    <= issued_q + LEN_W'(1);
      end
      if (pop && !hs)      credits_q <= credits_q - 2'd1;
      else if (!pop && hs) credits_q <= credits_q + 2'd1;
      pop_d_q <= pop;
      if (pop) begin
        in_clr_q  <= (issued_q == '0);
        in_last_q <= (remaining_q == LEN_W'(1));
      end
      if (pop_d_q) wr_ptr_q <= ~wr_ptr_q;
      if (hs)      rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, pop_d_q} - {1'b0, hs};
    end
  end

  // NOTE: buffer storage has no reset; count_q/pointers reset and mac_* outputs are gated by head_valid.
  always_ff @(posedge clk) begin
    if (pop_d_q) buf_mem[wr_ptr_q] <= incoming;
  end

`ifdef MAC_SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      stall_cnt <= '0;
    else if (start_ok)
      stall_cnt <= '0;
    else if (state_q == RUN && remaining_q != '0 && (a_empty || b_empty) &&
             stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with behavioural FIFOs A/B and a handshake monitor.
module tb_mac_operand_sequencer;
  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             a_empty, b_empty, a_rden, b_rden;
  logic [WIDTH-1:0] a_rddata, b_rddata, mac_a, mac_b;
  logic             mac_valid, mac_ready, mac_clr, mac_last, busy, done;
`ifdef MAC_SEQ_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  mac_operand_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .vec_len(vec_len),
    .a_empty(a_empty), .b_empty(b_empty), .a_rden(a_rden), .b_rden(b_rden),
    .a_rddata(a_rddata), .b_rddata(b_rddata), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_clr(mac_clr),
    .mac_last(mac_last), .busy(busy),
`ifdef MAC_SEQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .done(done));

  always #5 clk = ~clk;

  // Behavioural FIFOs: data appears on rddata one cycle after rden.
  logic [15:0] a_mem [64];
  logic [15:0] b_mem [64];
  int          a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;
  logic        flush = 1'b0;

  assign a_empty = (a_rd == a_wr);
  assign b_empty = (b_rd == b_wr);

  always @(posedge clk) begin
    if (flush) begin
      a_rd <= a_wr;
      b_rd <= b_wr;
    end else begin
      if (a_rden) begin a_rddata <= a_mem[a_rd % 64]; a_rd <= a_rd + 1; end
      if (b_rden) begin b_rddata <= b_mem[b_rd % 64]; b_rd <= b_rd + 1; end
    end
  end

  // Monitor: samples pre-edge values at each rising edge.
  logic [15:0] hs_a [64];
  logic [15:0] hs_b [64];
  logic        hs_clr [64];
  logic        hs_last [64];
  int          hs_cyc [64];
  int cyc = 0, hs_cnt = 0, pop_cnt = 0, skew_cnt = 0, bad_rd = 0;
  int done_cnt = 0, done_cyc = 0, busy_cnt = 0, st_cyc = 0;

  always @(posedge clk) begin
    if (mac_valid && mac_ready && hs_cnt < 64) begin
      hs_a[hs_cnt] = mac_a;  hs_b[hs_cnt] = mac_b;
      hs_clr[hs_cnt] = mac_clr; hs_last[hs_cnt] = mac_last;
      hs_cyc[hs_cnt] = cyc;  hs_cnt++;
    end
    if (a_rden) pop_cnt++;
    if (a_rden != b_rden) skew_cnt++;
    if ((a_rden || b_rden) && (a_empty || b_empty)) bad_rd++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (start && !busy && rstn) st_cyc = cyc;
    cyc++;
  end

  int tests = 0, failed = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [15:0] a, logic [15:0] b);
    a_mem[a_wr % 64] = a; a_wr = a_wr + 1;
    b_mem[b_wr % 64] = b; b_wr = b_wr + 1;
  endtask

  task automatic do_start(logic [LEN_W-1:0] len);
    @(negedge clk); start = 1'b1; vec_len = len;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(string tag, int base);
    int k = 0;
    while (done_cnt == base && k < 60) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    check({tag, " done pulses"}, done_cnt - base, 1);
  endtask

  task automatic flags(int base, int n, output logic [7:0] clr, output logic [7:0] last);
    clr = '0; last = '0;
    for (int i = 0; i < n; i++) begin
      clr[i]  = hs_clr[base + i];
      last[i] = hs_last[base + i];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hb, pb, db, bb, bad_b, sk_b, k;
    logic [7:0] cb, lb;

    rstn = 1'b0; start = 1'b0; vec_len = '0; mac_ready = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("reset mac_valid", mac_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rden", {a_rden, b_rden}, 0);
    check("reset mac_a/b", {mac_a, mac_b}, 0);

    // Test 1: vec_len=4, full FIFOs, MAC always ready.
    mac_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(16'(16'h11 + i), 16'(16'h21 + i));
    hb = hs_cnt; pb = pop_cnt; db = done_cnt;
    do_start(8'd4);
    wait_done("t1", db);
    check("t1 handshakes", hs_cnt - hb, 4);
    check("t1 pops", pop_cnt - pb, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1 pair%0d", i), {hs_a[hb+i], hs_b[hb+i]},
            {16'(16'h11 + i), 16'(16'h21 + i)});
    flags(hb, 4, cb, lb);
    check("t1 clr flags", cb, 8'b0001);
    check("t1 last flags", lb, 8'b1000);
    check("t1 start->valid latency", hs_cyc[hb] - st_cyc, 2);
    check("t1 back-to-back", hs_cyc[hb+3] - hs_cyc[hb], 3);
    check("t1 done after last", done_cyc - hs_cyc[hb+3], 1);

    // Test 2: vec_len=3, MAC stalls two cycles on the second pair.
    for (int i = 0; i < 3; i++) push(16'(16'hA1 + i), 16'(16'hB1 + i));
    hb = hs_cnt; pb = pop_cnt; db = done_cnt;
    do_start(8'd3);
    k = 0;
    while (hs_cnt != hb + 1 && k < 30) begin @(negedge clk); k++; end
    check("t2 first handshake seen", hs_cnt - hb, 1);
    mac_ready = 1'b0;
    check("t2 stall pair", {mac_valid, mac_a, mac_b}, {1'b1, 16'hA2, 16'hB2});
    @(negedge clk);
    check("t2 stall hold 1", {mac_valid, mac_a, mac_b, mac_clr, mac_last},
          {1'b1, 16'hA2, 16'hB2, 2'b00});
    @(negedge clk);
    check("t2 stall hold 2", {mac_valid, mac_a, mac_b, mac_clr, mac_last},
          {1'b1, 16'hA2, 16'hB2, 2'b00});
    mac_ready = 1'b1;
    wait_done("t2", db);
    check("t2 pops", pop_cnt - pb, 3);
    check("t2 handshakes", hs_cnt - hb, 3);
    check("t2 stall gap", hs_cyc[hb+1] - hs_cyc[hb], 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2 pair%0d", i), {hs_a[hb+i], hs_b[hb+i]},
            {16'(16'hA1 + i), 16'(16'hB1 + i)});
    flags(hb, 3, cb, lb);
    check("t2 last flags", lb, 8'b100);

    // Test 3: vec_len=5, B runs dry after two pairs and is refilled 6 cycles later.
    for (int i = 0; i < 5; i++) begin a_mem[a_wr % 64] = 16'(16'hC1 + i); a_wr = a_wr + 1; end
    for (int i = 0; i < 2; i++) begin b_mem[b_wr % 64] = 16'(16'hD1 + i); b_wr = b_wr + 1; end
    hb = hs_cnt; pb = pop_cnt; db = done_cnt; bad_b = bad_rd; sk_b = skew_cnt;
    do_start(8'd5);
    k = 0;
    while (!b_empty && k < 30) begin @(negedge clk); k++; end
    check("t3 B drained", b_empty, 1);
    check("t3 no read while B empty", {a_rden, b_rden}, 0);
    repeat (6) @(negedge clk);
    check("t3 pops during starve", pop_cnt - pb, 2);
    for (int i = 2; i < 5; i++) begin b_mem[b_wr % 64] = 16'(16'hD1 + i); b_wr = b_wr + 1; end
    wait_done("t3", db);
    check("t3 handshakes", hs_cnt - hb, 5);
    check("t3 pops", pop_cnt - pb, 5);
    check("t3 empty reads", bad_rd - bad_b, 0);
    check("t3 A/B rden skew", skew_cnt - sk_b, 0);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3 pair%0d", i), {hs_a[hb+i], hs_b[hb+i]},
            {16'(16'hC1 + i), 16'(16'hD1 + i)});
    flags(hb, 5, cb, lb);
    check("t3 clr flags", cb, 8'b00001);
    check("t3 last flags", lb, 8'b10000);
`ifdef MAC_SEQ_STALL_CNT_EN
    check("t3 stall_cnt", stall_cnt, 6);
`endif

    // Test 4: zero-length vector.
    pb = pop_cnt; db = done_cnt; bb = busy_cnt; hb = hs_cnt;
    do_start(8'd0);
    wait_done("t4", db);
    check("t4 pops", pop_cnt - pb, 0);
    check("t4 handshakes", hs_cnt - hb, 0);
    check("t4 done latency", done_cyc - st_cyc, 1);
    check("t4 busy cycles", busy_cnt - bb, 1);
`ifdef MAC_SEQ_STALL_CNT_EN
    check("t4 stall_cnt cleared", stall_cnt, 0);
`endif

    // Test 5: start pulse during RUN must be ignored.
    for (int i = 0; i < 3; i++) push(16'(16'hE1 + i), 16'(16'hE9 + i));
    hb = hs_cnt; pb = pop_cnt; db = done_cnt;
    do_start(8'd3);
    check("t5 busy in run", busy, 1);
    start = 1'b1; vec_len = 8'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5", db);
    check("t5 handshakes", hs_cnt - hb, 3);
    check("t5 pops", pop_cnt - pb, 3);
    check("t5 idle after done", busy, 0);
    flags(hb, 3, cb, lb);
    check("t5 last flags", lb, 8'b100);

    // Test 6: reset mid-vector, then a clean run.
    mac_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(16'(16'hF1 + i), 16'(16'hF5 + i));
    do_start(8'd4);
    repeat (2) @(negedge clk);
    check("t6 valid before reset", mac_valid, 1);
    rstn = 1'b0;
    #1;
    check("t6 reset outputs", {mac_valid, mac_clr, mac_last, busy, done, a_rden, b_rden}, 0);
    check("t6 reset data", {mac_a, mac_b}, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    rstn = 1'b1; mac_ready = 1'b1;
    push(16'h0051, 16'h0061);
    push(16'h0052, 16'h0062);
    hb = hs_cnt; db = done_cnt;
    do_start(8'd2);
    wait_done("t6", db);
    check("t6 handshakes", hs_cnt - hb, 2);
    check("t6 pair0", {hs_a[hb], hs_b[hb]}, {16'h0051, 16'h0061});
    check("t6 pair1", {hs_a[hb+1], hs_b[hb+1]}, {16'h0052, 16'h0062});
    flags(hb, 2, cb, lb);
    check("t6 clr flags", cb, 8'b01);
    check("t6 last flags", lb, 8'b10);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
